dram_arbiter: RTL

- Shares the single DRAM user command port (ren/wen, 27-bit addr, 128-bit data, 16-bit mask, busy, rdata_valid) between two requesters, e.g. CPU memory path (m0) and SD-card DMA (m1).
- Blocks all traffic until DRAM calibration completes, then grants round-robin, holds one command in a registered output stage until DRAM accepts it, and routes in-order read data back to the requester that issued the read.

---
 rtl/dram_arbiter.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// Two-requester arbiter for the DRAM user command port: calibration gate,
// round-robin grant, one registered command stage and in-order read routing.
//
// Ports:
//   clk_166_67_mhz, dram_rstx_async  clock, async active-low reset
//   mN_ren/wen/addr/wdata/wmask      requester N command, held until mN_ack
//   mN_ack                           one-cycle pulse, request captured
//   mN_rdata/mN_rvalid               read data returned to requester N
//   dram_ren/wen/addr/wdata/wmask    registered command to DRAM
//   dram_busy                        DRAM not accepting this cycle
//   dram_init_calib_complete         calibration finished
//   dram_rdata/dram_rdata_valid      in-order read data from DRAM
//   ready                            calibration seen, arbiter running
//   err                              sticky protocol error
module dram_arbiter #(
   parameter int ADDR_W   = 27,
   parameter int DATA_W   = 128,
   parameter int MASK_W   = 16,
   parameter int RD_DEPTH = 4
) (
   input  logic              clk_166_67_mhz,
   input  logic              dram_rstx_async,
   input  logic              m0_ren,
   input  logic              m0_wen,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [MASK_W-1:0] m0_wmask,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_rvalid,
   input  logic              m1_ren,
   input  logic              m1_wen,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [MASK_W-1:0] m1_wmask,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_rvalid,
   output logic              dram_ren,
   output logic              dram_wen,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [DATA_W-1:0] dram_wdata,
   output logic [MASK_W-1:0] dram_wmask,
   input  logic              dram_busy,
   input  logic              dram_init_calib_complete,
   input  logic [DATA_W-1:0] dram_rdata,
   input  logic              dram_rdata_valid,
   output logic              ready,
   output logic              err
);

   localparam int PW = $clog2(RD_DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = CW + 1;

   typedef enum logic {
      CALIB,
      RUN
   } state_t;

   state_t state_q, state_d;

   logic rr_q;

   logic              stg_ren_q;
   logic              stg_wen_q;
   logic              stg_id_q;
   logic [ADDR_W-1:0] stg_addr_q;
   logic [DATA_W-1:0] stg_wdata_q;
   logic [MASK_W-1:0] stg_wmask_q;

   logic [RD_DEPTH-1:0] tag_q;
   logic [PW-1:0]       wr_ptr_q;
   logic [PW-1:0]       rd_ptr_q;
   logic [CW-1:0]       cnt_q;

   logic              rv0_q;
   logic              rv1_q;
   logic [DATA_W-1:0] rd0_q;
   logic [DATA_W-1:0] rd1_q;
   logic              err_q;

   logic              stg_valid;
   logic              accept;
   logic              loadable;
   logic              push;
   logic              pop;
   logic              drop;
   logic              head;
   logic [IW-1:0]     inflight;
   logic              rd_room;
   logic              elig0;
   logic              elig1;
   logic              gnt0;
   logic              gnt1;
   logic              gnt;
   logic              sel_ren;
   logic              sel_wen;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [MASK_W-1:0] sel_wmask;
   logic              bad_req;

   assign stg_valid = stg_ren_q | stg_wen_q;
   assign accept    = stg_valid & ~dram_busy;
   assign loadable  = ~stg_valid | accept;

   // Only pure reads travel as reads; an illegal ren&wen became a write.
   assign push = accept & stg_ren_q;
   assign pop  = dram_rdata_valid & (cnt_q != '0);
   assign drop = dram_rdata_valid & (cnt_q == '0);
   assign head = tag_q[rd_ptr_q];

   // A pop this cycle frees a slot that a read granted now may take.
   assign inflight = IW'(cnt_q)
                   + IW'(stg_ren_q)
                   - IW'(pop);
   assign rd_room  = inflight < IW'(RD_DEPTH);

   assign elig0 = m0_wen | (m0_ren & rd_room);
   assign elig1 = m1_wen | (m1_ren & rd_room);

   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         state_q <= CALIB;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      unique case (state_q)
         CALIB: begin
            if (dram_init_calib_complete) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (loadable) begin
               gnt0 = elig0 & (~elig1 | ~rr_q);
               gnt1 = elig1 & (~elig0 | rr_q);
            end
         end
         default: state_d = CALIB;
      endcase
   end

   assign gnt       = gnt0 | gnt1;
   assign sel_ren   = gnt1 ? m1_ren   : m0_ren;
   assign sel_wen   = gnt1 ? m1_wen   : m0_wen;
   assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
   assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
   assign sel_wmask = gnt1 ? m1_wmask : m0_wmask;
   assign bad_req   = gnt & sel_ren & sel_wen;

   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         rr_q <= 1'b0;
      end else if (gnt) begin
         rr_q <= gnt0;
      end
   end

   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         stg_ren_q   <= 1'b0;
         stg_wen_q   <= 1'b0;
         stg_id_q    <= 1'b0;
         stg_addr_q  <= '0;
         stg_wdata_q <= '0;
         stg_wmask_q <= '0;
      end else if (gnt) begin
         stg_ren_q   <= sel_ren & ~sel_wen;
         stg_wen_q   <= sel_wen;
         stg_id_q    <= gnt1;
         stg_addr_q  <= sel_addr;
         stg_wdata_q <= sel_wdata;
         stg_wmask_q <= sel_wmask;
      end else if (accept) begin
         stg_ren_q   <= 1'b0;
         stg_wen_q   <= 1'b0;
      end
   end

   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         tag_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            tag_q[wr_ptr_q] <= stg_id_q;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         rv0_q <= 1'b0;
         rv1_q <= 1'b0;
         rd0_q <= '0;
         rd1_q <= '0;
      end else begin
         rv0_q <= pop & ~head;
         rv1_q <= pop & head;
         if (pop & ~head) begin
            rd0_q <= dram_rdata;
         end
         if (pop & head) begin
            rd1_q <= dram_rdata;
         end
      end
   end

   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         err_q <= 1'b0;
      end else if (bad_req | drop) begin
         err_q <= 1'b1;
      end
   end

   assign m0_ack     = gnt0;
   assign m1_ack     = gnt1;
   assign m0_rvalid  = rv0_q;
   assign m1_rvalid  = rv1_q;
   assign m0_rdata   = rd0_q;
   assign m1_rdata   = rd1_q;
   assign dram_ren   = stg_ren_q;
   assign dram_wen   = stg_wen_q;
   assign dram_addr  = stg_addr_q;
   assign dram_wdata = stg_wdata_q;
   assign dram_wmask = stg_wmask_q;
   assign ready      = (state_q == RUN);
   assign err        = err_q;

endmodule
